// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit: sub-word extraction, read-modify-write stores, misalignment rejection
// Word-indexed data memory interface; sub-word stores read the word first, then write the merged word.
module mem_access_unit #(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_rdata,
  output logic         resp_misaligned,
  output logic         MemRead,
  output logic         MemWrite,
  output logic [N-1:0] address,
  output logic [W-1:0] write_data,
  input  logic [W-1:0] read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e       state_q, state_d;
  logic         write_q, write_d;
  logic [1:0]   size_q, size_d;
  logic         uns_q, uns_d;
  logic [N-1:0] addr_q, addr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic [W-1:0] word_q, word_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic         mis_q, mis_d;

  logic         misaligned;
  logic [4:0]   shamt;
  logic [W-1:0] lane_word, load_ext, lane_mask, lane_data, merged;

  always_comb begin
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Halfword requests are aligned here, so the byte shift also selects the halfword lane.
  assign shamt     = {addr_q[1:0], 3'b000};
  assign lane_word = read_data >> shamt;
  assign lane_mask = ((size_q == 2'b00) ? W'(8'hFF) : W'(16'hFFFF)) << shamt;
  assign lane_data = wdata_q << shamt;
  assign merged    = (word_q & ~lane_mask) | (lane_data & lane_mask);

  always_comb begin
    case (size_q)
      2'b00:   load_ext = uns_q ? {{(W-8){1'b0}}, lane_word[7:0]}
                                : {{(W-8){lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_ext = uns_q ? {{(W-16){1'b0}}, lane_word[15:0]}
                                : {{(W-16){lane_word[15]}}, lane_word[15:0]};
      default: load_ext = read_data;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    mis_d      = mis_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    write_data = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          mis_d   = misaligned;
          rdata_d = '0;
          if (misaligned)                          state_d = RESP;
          else if (req_write && req_size == 2'b10) state_d = WR;
          else                                     state_d = RD;
        end
      end
      RD: begin
        MemRead = 1'b1;
        word_d  = read_data;
        if (write_q) begin
          state_d = WR;
        end else begin
          rdata_d = load_ext;
          state_d = RESP;
        end
      end
      WR: begin
        MemWrite   = 1'b1;
        write_data = (size_q == 2'b10) ? wdata_q : merged;
        state_d    = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
    endcase
  end

  assign address         = (MemRead || MemWrite) ? {2'b00, addr_q[N-1:2]} : '0;
  assign resp_rdata      = resp_valid ? rdata_q : '0;
  assign resp_misaligned = resp_valid & mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table plus randomized transactions against a byte-level reference model
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_misaligned, MemRead, MemWrite;
  logic [31:0] resp_rdata, address, write_data, read_data;

  logic [31:0] mem [16];
  logic [31:0] refmem [16];
  int pass = 0;
  int total = 0;

  typedef struct packed {
    logic        mis;
    logic [31:0] rdata;
    logic [31:0] word;
    logic [3:0]  lat;
    logic [1:0]  nrd;
    logic [1:0]  nwr;
  } model_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    model_t      e;
  } vec_t;

  mem_access_unit #(.N(32), .W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  assign read_data = mem[address[3:0]];
  always @(posedge clk) if (MemWrite) mem[address[3:0]] <= write_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference: memory word viewed as four little-endian bytes.
  function automatic model_t model(input logic wr, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] a, input logic [31:0] wd, input logic [31:0] old);
    model_t m;
    logic [7:0] b [4];
    int k;
    k = int'(a[1:0]);
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    m.mis   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    m.word  = old;
    m.rdata = 32'h0;
    if (m.mis) begin
      m.lat = 4'd1; m.nrd = 2'd0; m.nwr = 2'd0;
    end else if (!wr) begin
      m.lat = 4'd2; m.nrd = 2'd1; m.nwr = 2'd0;
      if (sz == 2'd0) begin
        m.rdata = {24'h0, b[k]};
        if (!uns && b[k][7]) m.rdata = m.rdata | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        m.rdata = {16'h0, b[k+1], b[k]};
        if (!uns && b[k+1][7]) m.rdata = m.rdata | 32'hFFFF_0000;
      end else begin
        m.rdata = old;
      end
    end else begin
      m.nwr = 2'd1;
      if (sz == 2'd2) begin
        m.lat = 4'd2; m.nrd = 2'd0; m.word = wd;
      end else begin
        m.lat = 4'd3; m.nrd = 2'd1;
        b[k] = wd[7:0];
        if (sz == 2'd1) b[k+1] = wd[15:8];
        m.word = {b[3], b[2], b[1], b[0]};
      end
    end
    return m;
  endfunction

  task automatic run(input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input model_t e);
    int lat, nrd, nwr;
    logic [31:0] held;
    @(negedge clk);
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; resp_ready = 1'b0;
    @(posedge clk); #1;
    // Garbage on the request bus while busy must be ignored.
    req_valid = 1'($urandom); req_write = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1; nrd = 0; nwr = 0;
    while (!resp_valid && lat < 6) begin
      if (MemRead && MemWrite) chk("both_strobes", 32'h1, 32'h0);
      if (MemRead) begin
        nrd++;
        chk("rd_address", address, {2'b00, a[31:2]});
      end
      if (MemWrite) begin
        nwr++;
        chk("wr_address", address, {2'b00, a[31:2]});
        chk("wr_data", write_data, e.word);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(e.lat));
    chk("resp_misaligned", {31'h0, resp_misaligned}, {31'h0, e.mis});
    chk("resp_rdata", resp_rdata, e.rdata);
    chk("memread_cycles", 32'(nrd), 32'(e.nrd));
    chk("memwrite_cycles", 32'(nwr), 32'(e.nwr));
    held = resp_rdata;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      chk("resp_hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("resp_hold_rdata", resp_rdata, held);
      chk("resp_hold_strobes_addr", {MemRead, MemWrite, 30'h0} | address, 32'h0);
    end
    req_valid = 1'b0;
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_drop", {31'h0, resp_valid}, 32'h0);
    chk("back_idle", {31'h0, req_ready}, 32'h1);
    chk("mem_word", mem[a[5:2]], e.word);
    refmem[a[5:2]] = e.word;
  endtask

  vec_t vecs [11];

  initial begin
    model_t m;
    logic wr, uns;
    logic [1:0] sz;
    logic [31:0] a, wd;
    int n;

    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h0123_4567;
    mem[1] = 32'h8081_82F3;
    mem[2] = 32'h1122_3344;
    mem[3] = 32'h0000_0000;
    for (int i = 0; i < 16; i++) refmem[i] = mem[i];

    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h4, 32'h0,   '{1'b0, 32'hFFFF_FFF3, 32'h8081_82F3, 4'd2, 2'd1, 2'd0}};
    vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h6, 32'h0,   '{1'b0, 32'h0000_8081, 32'h8081_82F3, 4'd2, 2'd1, 2'd0}};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'hA, 32'hAB,  '{1'b0, 32'h0, 32'h11AB_3344, 4'd3, 2'd1, 2'd1}};
    vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'hC, 32'hDEAD_BEEF, '{1'b0, 32'h0, 32'hDEAD_BEEF, 4'd2, 2'd0, 2'd1}};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h3, 32'h0,   '{1'b1, 32'h0, 32'h0123_4567, 4'd1, 2'd0, 2'd0}};
    vecs[5]  = '{1'b0, 2'd3, 1'b0, 32'h4, 32'h0,   '{1'b1, 32'h0, 32'h8081_82F3, 4'd1, 2'd0, 2'd0}};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h4, 32'h0,   '{1'b0, 32'hFFFF_82F3, 32'h8081_82F3, 4'd2, 2'd1, 2'd0}};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,   '{1'b0, 32'h11AB_3344, 32'h11AB_3344, 4'd2, 2'd1, 2'd0}};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'hE, 32'hCAFE, '{1'b0, 32'h0, 32'hCAFE_BEEF, 4'd3, 2'd1, 2'd1}};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'hF, 32'h0,   '{1'b0, 32'h0000_00CA, 32'hCAFE_BEEF, 4'd2, 2'd1, 2'd0}};
    vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h2, 32'h5555_AAAA, '{1'b1, 32'h0, 32'h0123_4567, 4'd1, 2'd0, 2'd0}};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_mis", {31'h0, resp_misaligned}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
    chk("rst_addr_wdata", address | write_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd, vecs[i].e);

    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
      a = 32'($urandom_range(0, 63)); wd = $urandom;
      m = model(wr, sz, uns, a, wd, refmem[a[5:2]]);
      run(wr, sz, uns, a, wd, m);
    end

    // Reset asserted while the byte store sits in WR with no response pending.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'hA; req_wdata = 32'h0000_0055; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!MemWrite && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reached_wr", {31'h0, MemWrite}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_memwrite_drop", {31'h0, MemWrite}, 32'h0);
    chk("async_memread_low", {31'h0, MemRead}, 32'h0);
    chk("async_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_no_resp", {31'h0, resp_valid}, 32'h0);
      chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    end
    chk("post_rst_word_unchanged", mem[2], refmem[2]);

    run(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, model(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, refmem[2]));

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter N, default 32, address width.
REQ-002 SHALL have parameter W, default 32, data word width; byte/halfword logic is fixed to W=32.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 SHALL have these ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
- req_addr  input  N  byte address.
- req_wdata  input  W  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  W  extended load data; 0 for stores.
- resp_misaligned  output  1  request was rejected with no memory access.
- MemRead  output  1  data memory read enable.
- MemWrite  output  1  data memory write enable.
- address  output  N  data memory word index.
- write_data  output  W  data memory write word.
- read_data  input  W  data memory read word, combinational from address.

Function
REQ-005 SHALL implement the FSM states IDLE, RD, WR, RESP.
REQ-006 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid & req_ready, and all req_* fields are registered at acceptance.
REQ-007 SHALL treat these requests as misaligned: halfword with addr[0]=1, word with addr[1:0]!=0, and any req_size=11.
- Accepted misaligned request: IDLE->RESP with resp_misaligned=1 and resp_rdata=0.
- No MemRead/MemWrite pulse is issued for it.
REQ-008 SHALL, for an aligned request, go IDLE->RD for loads and for byte/halfword stores, and IDLE->WR for word stores.
REQ-009 SHALL, in RD, assert MemRead=1 and address={2'b00, addr[N-1:2]}, and capture read_data at the clock edge.
- Load: RD->RESP.
- Sub-word store: RD->WR.
REQ-010 SHALL, in WR, assert MemWrite=1 with the same address and write_data set as follows, then go WR->RESP.
- Word store: req_wdata.
- Sub-word store: the captured word with the addressed lane replaced.
REQ-011 SHALL use little-endian lanes: byte k occupies bits 8k+7:8k, k=addr[1:0]; halfword lane is addr[1].
REQ-012 SHALL form load data from the captured word: extract the lane, right-align it, then zero-extend (req_unsigned=1) or sign-extend (req_unsigned=0); word loads pass unchanged.
REQ-013 SHALL hold resp_valid=1 in RESP with stable resp_rdata/resp_misaligned until resp_ready=1, then RESP->IDLE.
- A new request is not accepted in that same cycle.
REQ-014 SHALL decode MemRead/MemWrite from state only, never both high, and pulse MemWrite exactly one cycle per aligned store.
REQ-015 SHALL give these latencies from the acceptance edge T:
- Misaligned: resp_valid at T+1.
- Load or word store: resp_valid at T+2.
- Sub-word store: resp_valid at T+3.
REQ-016 SHALL ignore req_* inputs in all states other than IDLE.
REQ-017 SHALL drive address and write_data to 0 whenever MemRead and MemWrite are both 0.

Reset
REQ-018 SHALL, while rst_n=0, force state=IDLE and all registers to 0.
- Outputs: req_ready=1, resp_valid=0, resp_misaligned=0, resp_rdata=0, MemRead=0, MemWrite=0.
REQ-019 SHALL, on rst_n assertion mid-operation (including in WR), drop MemWrite immediately and asynchronously, discard the operation, and produce no response.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Memory word 1 = 0x8081_82F3; load byte signed at addr 0x4 -> MemRead one cycle, resp_rdata=0xFFFF_FFF3 at T+2.
- Same word; load halfword unsigned at addr 0x6 -> resp_rdata=0x0000_8081.
- Word 2 = 0x1122_3344; store byte 0xAB at addr 0xA -> RD, WR with write_data=0x11AB_3344, address=2, resp at T+3.
- Word store 0xDEAD_BEEF at addr 0xC -> no MemRead, MemWrite one cycle with address=3, resp at T+2.
- Halfword load at addr 0x3 -> resp_misaligned=1 at T+1, MemRead/MemWrite never asserted.
- rst_n low during WR of a byte store, with resp_ready held 0 -> MemWrite falls without a clock edge, word unchanged, req_ready=1 after release.
